// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive FIFO: entry layout and
// status register bit positions.
package uart_pkg;

   localparam int unsigned RX_DATA_W = 8;

   typedef struct packed {
      logic                 brk;
      logic                 stop;
      logic                 parity;
      logic [RX_DATA_W-1:0] data;
   } rx_entry_t;

   localparam int unsigned ST_DATA_READY = 7;
   localparam int unsigned ST_OVERFLOW   = 6;
   localparam int unsigned ST_STOP_ERR   = 5;
   localparam int unsigned ST_BREAK_ERR  = 4;
   localparam int unsigned ST_PARITY_ERR = 3;
   localparam int unsigned ST_EMPTY      = 2;
   localparam int unsigned ST_FULL       = 1;
   localparam int unsigned ST_READ_ERR   = 0;

   localparam logic [7:0] STATUS_RESET = 8'h04;

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port register array: synchronous write, registered read.
module uart_fifo_mem #(
   parameter int unsigned WIDTH = 11,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Read register holds its value between accepted reads.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)   rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO with sticky receive status register.
// Optional UART_RX_FIFO_DROP_ERR_EN: errored frames are dropped and flagged at write time.
module uart_rx_fifo #(
   parameter int unsigned DATA_SIZE  = 8,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned ADDR_SIZE  = $clog2(FIFO_DEPTH)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 wr_en,
   input  logic [DATA_SIZE-1:0] wr_data,
   input  logic                 wr_parity_error,
   input  logic                 wr_stop_error,
   input  logic                 wr_break_error,
   input  logic                 rd_en,
   output logic [DATA_SIZE-1:0] rd_data,
   output logic                 rd_valid,
   output logic                 rd_parity_error,
   output logic                 rd_stop_error,
   output logic                 rd_break_error,
   output logic                 full,
   output logic                 empty,
   output logic [ADDR_SIZE:0]   count,
   input  logic                 clr_status,
   output logic [7:0]           status_register
);
   import uart_pkg::*;

   localparam int unsigned EW = DATA_SIZE + 3;
   localparam int unsigned PW = ADDR_SIZE + 1;

   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          wr_store, wr_accept, rd_accept;
   logic          ovf_set, erd_set, par_set, stp_set, brk_set;
   logic          ovf_q, erd_q, par_q, stp_q, brk_q;
   logic [EW-1:0] mem_wdata, mem_rdata;

   assign count = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (count == PW'(FIFO_DEPTH));

   // Acceptance and sticky-set events for this cycle.
   always_comb begin
      rd_accept = rd_en & ~empty;
`ifdef UART_RX_FIFO_DROP_ERR_EN
      wr_store  = wr_en & ~(wr_parity_error | wr_stop_error | wr_break_error);
      par_set   = (wr_en & wr_parity_error) | (rd_valid & rd_parity_error);
      stp_set   = (wr_en & wr_stop_error)   | (rd_valid & rd_stop_error);
      brk_set   = (wr_en & wr_break_error)  | (rd_valid & rd_break_error);
`else
      wr_store  = wr_en;
      par_set   = rd_valid & rd_parity_error;
      stp_set   = rd_valid & rd_stop_error;
      brk_set   = rd_valid & rd_break_error;
`endif
      wr_accept = wr_store & (~full | rd_accept);
      ovf_set   = wr_store & full & ~rd_accept;
      erd_set   = rd_en & empty;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         rd_valid <= 1'b0;
      end else begin
         if (wr_accept) wr_ptr <= wr_ptr + PW'(1);
         if (rd_accept) rd_ptr <= rd_ptr + PW'(1);
         rd_valid <= rd_accept;
      end
   end

   // Sticky bits: a set event in the same cycle as clr_status wins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ovf_q <= 1'b0;
         erd_q <= 1'b0;
         par_q <= 1'b0;
         stp_q <= 1'b0;
         brk_q <= 1'b0;
      end else begin
         ovf_q <= (ovf_q & ~clr_status) | ovf_set;
         erd_q <= (erd_q & ~clr_status) | erd_set;
         par_q <= (par_q & ~clr_status) | par_set;
         stp_q <= (stp_q & ~clr_status) | stp_set;
         brk_q <= (brk_q & ~clr_status) | brk_set;
      end
   end

   assign mem_wdata = {wr_break_error, wr_stop_error, wr_parity_error, wr_data};

   uart_fifo_mem #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH),
      .AW    (ADDR_SIZE)
   ) u_mem (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (wr_accept),
      .wr_addr (wr_ptr[ADDR_SIZE-1:0]),
      .wr_data (mem_wdata),
      .rd_en   (rd_accept),
      .rd_addr (rd_ptr[ADDR_SIZE-1:0]),
      .rd_data (mem_rdata)
   );

   assign {rd_break_error, rd_stop_error, rd_parity_error, rd_data} = mem_rdata;

   always_comb begin
      status_register                = '0;
      status_register[ST_DATA_READY] = ~empty;
      status_register[ST_OVERFLOW]   = ovf_q;
      status_register[ST_STOP_ERR]   = stp_q;
      status_register[ST_BREAK_ERR]  = brk_q;
      status_register[ST_PARITY_ERR] = par_q;
      status_register[ST_EMPTY]      = empty;
      status_register[ST_FULL]       = full;
      status_register[ST_READ_ERR]   = erd_q;
   end

endmodule
